cache_port_arb: RTL
===================

CACHE_PORT_ARB -- requirements
Module: cache_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, cache word address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TMO_CYC, default 255, maximum cycles waiting for cache_ack (range 1..255).
REQ-004 SHALL have port clk_in  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_in  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports reqN_valid  input  1, for N=0,1  requester N has a pending access.
REQ-007 SHALL have ports reqN_wr  input  1  1=write, 0=read.
REQ-008 SHALL have ports reqN_addr  input  ADDR_W  access address.
REQ-009 SHALL have ports reqN_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports reqN_ready  output  1  one-cycle accept strobe.
REQ-011 SHALL have ports respN_valid  output  1  one-cycle completion strobe.
REQ-012 SHALL have ports respN_rdata  output  DATA_W  read data, valid with respN_valid.
REQ-013 SHALL have port cache_req  output  1  one-cycle access start to the cache.
REQ-014 SHALL have ports cache_wr  output  1, cache_addr  output  ADDR_W, cache_wdata  output  DATA_W  latched access, stable from cache_req until completion.
REQ-015 SHALL have ports cache_ack  input  1 and cache_rdata  input  DATA_W  cache completion and read data.
REQ-016 SHALL have port tmo_err  output  1  one-cycle timeout strobe.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-018 In IDLE with any reqN_valid, SHALL pulse reqN_ready for the winner, latch its wr/addr/wdata and requester id, and go to ISSUE next cycle.
REQ-019 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; single valid requester is granted immediately.
REQ-020 ISSUE SHALL pulse cache_req for exactly one cycle, then enter WAIT.
REQ-021 WAIT SHALL hold until cache_ack=1, capture cache_rdata (reads only), and enter RESP; cache_ack outside WAIT SHALL be ignored.
REQ-022 RESP SHALL pulse respN_valid of the latched requester for one cycle with captured rdata (zero for writes), then return to IDLE.
REQ-023 Minimum acceptance-to-response latency SHALL be 3 cycles (accept, ISSUE, WAIT with ack, RESP on 4th edge).
REQ-024 A 8-bit wait counter SHALL clear on entering WAIT; reaching TMO_CYC without ack SHALL pulse tmo_err, pulse respN_valid with rdata=0, and return to IDLE.
REQ-025 A requester's reqN_valid deasserting after acceptance SHALL NOT abort the access.
REQ-026 No new request SHALL be accepted outside IDLE; reqN_ready SHALL never assert for both requesters in one cycle.

Reset
REQ-027 On reset_in=1, SHALL immediately enter IDLE and drive all outputs 0.
REQ-028 Reset SHALL set last-granted to 1 so requester 0 wins the first tie.
REQ-029 Reset mid-access SHALL discard the access with no respN_valid or tmo_err.

Configuration
REQ-030 With ARB_PERF_CNT_EN defined, SHALL add outputs grant0_cnt, grant1_cnt, stall_cnt (12 bits each): grants per requester and cycles in WAIT, saturating at 12'hFFF, cleared by reset.
REQ-031 Without ARB_PERF_CNT_EN, those ports and counters SHALL be absent; other behaviour identical.

Verification
REQ-032 req0 read addr 13'h0010, cache_ack on first WAIT cycle with rdata 32'hDEADBEEF -> req0_ready cycle 0, cache_req cycle 1, resp0_valid cycle 3 with 32'hDEADBEEF.
REQ-033 req0 and req1 held valid from reset release -> grants 0,1,0,1; no double ready.
REQ-034 req1 write addr 13'h1FFF data 32'h12345678 -> cache_wr=1, cache_addr/wdata stable until ack; resp1_valid with rdata 0.
REQ-035 no cache_ack, TMO_CYC=4 -> tmo_err and resp0_valid 4 cycles after entering WAIT; next request then accepted.
REQ-036 reset_in pulsed during WAIT -> outputs 0, no response; next tie grants requester 0.
REQ-037 ARB_PERF_CNT_EN, 3 accesses with 2 wait cycles each -> grant0_cnt+grant1_cnt=3, stall_cnt=6.

Source files
------------

// File: rtl/cache_port_arb.sv
// Two-requester round-robin arbiter in front of a single-ported cache.
// Sequence per access: IDLE (accept) -> ISSUE (cache_req) -> WAIT (ack or
// timeout) -> RESP (completion strobe to the owning requester).
// Optional build macro: ARB_PERF_CNT_EN adds saturating grant/stall counters.
module cache_port_arb #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              req0_valid,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              cache_req,
  output logic              cache_wr,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wdata,
  input  logic              cache_ack,
  input  logic [DATA_W-1:0] cache_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [11:0]       grant0_cnt,
  output logic [11:0]       grant1_cnt,
  output logic [11:0]       stall_cnt,
`endif
  output logic              tmo_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_last;
  logic                r_id;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [7:0]          r_wcnt;
  logic                r_tmo;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_tmo_hit;

  // On a tie the requester not granted last wins; a lone requester wins outright.
  assign w_gnt0    = req0_valid & (~req1_valid | r_last);
  assign w_gnt1    = req1_valid & (~req0_valid | ~r_last);
  assign w_tmo_hit = (r_wcnt == TMO_LAST);

  assign cache_wr    = r_wr;
  assign cache_addr  = r_addr;
  assign cache_wdata = r_wdata;

  // State register.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and strobe outputs; ready is gated so reset forces every output low.
  always_comb begin
    w_next      = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    resp0_rdata = '0;
    resp1_rdata = '0;
    cache_req   = 1'b0;
    tmo_err     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = w_gnt0 & ~reset_in;
        req1_ready = w_gnt1 & ~reset_in;
        if (w_gnt0 | w_gnt1) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        cache_req = 1'b1;
        w_next    = S_WAIT;
      end
      S_WAIT: begin
        if (cache_ack || w_tmo_hit) w_next = S_RESP;
      end
      S_RESP: begin
        resp0_valid = ~r_id;
        resp1_valid = r_id;
        resp0_rdata = r_id ? '0 : r_rdata;
        resp1_rdata = r_id ? r_rdata : '0;
        tmo_err     = r_tmo;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latched access, wait counter and captured read data.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wcnt  <= '0;
      r_tmo   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_id    <= w_gnt1;
            r_last  <= w_gnt1;
            r_wr    <= w_gnt1 ? req1_wr    : req0_wr;
            r_addr  <= w_gnt1 ? req1_addr  : req0_addr;
            r_wdata <= w_gnt1 ? req1_wdata : req0_wdata;
            r_rdata <= '0;
            r_tmo   <= 1'b0;
          end
        end
        S_ISSUE: r_wcnt <= '0;
        S_WAIT: begin
          r_wcnt <= r_wcnt + 8'd1;
          // An ack in the same cycle as the timeout limit still completes normally.
          if (cache_ack) begin
            if (!r_wr) r_rdata <= cache_rdata;
          end else if (w_tmo_hit) begin
            r_tmo <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  // Saturating grant counters per requester and WAIT-cycle counter.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      grant0_cnt <= '0;
      grant1_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (r_state == S_IDLE && w_gnt0 && grant0_cnt != '1) grant0_cnt <= grant0_cnt + 12'd1;
      if (r_state == S_IDLE && w_gnt1 && grant1_cnt != '1) grant1_cnt <= grant1_cnt + 12'd1;
      if (r_state == S_WAIT && stall_cnt != '1)            stall_cnt  <= stall_cnt + 12'd1;
    end
  end
`endif

endmodule
